// File: rtl/stream_compare_pkg.sv
// Shared definitions for the stream_compare checker: compare-mode codes and
// the saturating increment used by the statistics counters.
package stream_compare_pkg;

    // Compare modes selected by the MODE parameter.
    localparam int CMP_EXACT = 0;
    localparam int CMP_TOL   = 1;

    // Widest counter the helper below supports; CWIDTH must not exceed it.
    localparam int CNT_MAXW = 64;

    // Increment that sticks at the supplied all-ones limit instead of wrapping.
    function automatic logic [CNT_MAXW-1:0] sat_inc(
        input logic [CNT_MAXW-1:0] value,
        input logic [CNT_MAXW-1:0] limit
    );
        return (value == limit) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/stream_compare_lane.sv
// One compare lane: extends both operands by one bit (sign or zero), subtracts
// without truncation and registers the result (pipeline stage 1). From the
// registered difference it derives the magnitude, the saturated magnitude
// reported on abs_sub and the lane pass flag. The pass flag and saturated
// magnitude are combinational from stage 1 and get registered by the top.
module stream_compare_lane
    import stream_compare_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int MODE   = CMP_EXACT,
    parameter int ABDBIT = 4,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DWIDTH-1:0] d0,
    input  logic [DWIDTH-1:0] d1,
    output logic [DWIDTH-1:0] abs_sat,
    output logic              pass
);

    logic [DWIDTH:0] ext0;
    logic [DWIDTH:0] ext1;
    logic [DWIDTH:0] diff_d;
    logic [DWIDTH:0] diff_q;
    logic [DWIDTH:0] mag;

    // Operand extension and full-width difference; DWIDTH+1 bits always hold
    // the exact difference of two DWIDTH-bit values of the same signedness.
    always_comb begin
        ext0 = '0;
        ext1 = '0;
        if (SIGNED != 0) begin
            ext0 = {d0[DWIDTH-1], d0};
            ext1 = {d1[DWIDTH-1], d1};
        end else begin
            ext0 = {1'b0, d0};
            ext1 = {1'b0, d1};
        end
        diff_d = ext0 - ext1;
    end

    // Stage 1: hold the extended difference of the accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q <= '0;
        end else if (load) begin
            diff_q <= diff_d;
        end
    end

    // Magnitude, saturation to DWIDTH bits and the pass decision. Exact mode
    // tests the difference for zero, which is equivalent to d0 == d1 because
    // the extended subtraction cannot wrap. Tolerance mode uses the
    // unsaturated magnitude.
    always_comb begin
        mag     = diff_q[DWIDTH] ? (~diff_q + 1'b1) : diff_q;
        abs_sat = mag[DWIDTH] ? {DWIDTH{1'b1}} : mag[DWIDTH-1:0];
        if (MODE == CMP_TOL) begin
            pass = ((mag >> ABDBIT) == '0);
        end else begin
            pass = (diff_q == '0);
        end
    end

endmodule

// File: rtl/stream_compare.sv
// stream_compare: pipelined N-lane result checker with running statistics.
//
// Beat protocol: dvalid qualifies d0/d1/lane_en in the same cycle; there is no
// ready, every valid beat is accepted and the block sustains one beat per
// cycle. Results appear two cycles later qualified by r_valid; error pulses
// for exactly the cycles whose r_valid beat has an enabled failing lane.
//
// clr has priority over every same-cycle update: it drops both pipeline valid
// bits (a beat presented with clr is discarded) and zeroes the counters, the
// sticky flag and the capture registers.
//
// Optional feature: define STREAM_COMPARE_CAPTURE_EN to build the
// first-failure capture registers. Without it the first_* outputs are tied to
// zero and the port list is unchanged.
module stream_compare
    import stream_compare_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int N      = 4,
    parameter int MODE   = CMP_EXACT,
    parameter int ABDBIT = 4,
    parameter int SIGNED = 1,
    parameter int CWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [DWIDTH*N-1:0] d0,
    input  logic [DWIDTH*N-1:0] d1,
    input  logic                dvalid,
    input  logic [N-1:0]        lane_en,
    output logic [N-1:0]        r,
    output logic                r_valid,
    output logic [DWIDTH*N-1:0] abs_sub,
    output logic                error,
    output logic                err_sticky,
    output logic [CWIDTH-1:0]   beat_cnt,
    output logic [CWIDTH-1:0]   err_cnt,
    output logic                first_valid,
    output logic [CWIDTH-1:0]   first_beat,
    output logic [N-1:0]        first_mask,
    output logic [DWIDTH*N-1:0] first_d0,
    output logic [DWIDTH*N-1:0] first_d1
);

    // All-ones value of a CWIDTH counter, widened for the shared helper.
    localparam logic [CNT_MAXW-1:0] CNT_LIMIT = CNT_MAXW'({CWIDTH{1'b1}});

    logic                s1_valid;
    logic [N-1:0]        s1_lane_en;
    logic [DWIDTH*N-1:0] lane_abs;
    logic [N-1:0]        lane_pass;
    logic [N-1:0]        r_next;
    logic                beat_fail;

    // Per-lane datapath; each lane owns its stage-1 difference register.
    for (genvar i = 0; i < N; i++) begin : g_lane
        stream_compare_lane #(
            .DWIDTH (DWIDTH),
            .MODE   (MODE),
            .ABDBIT (ABDBIT),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (dvalid),
            .d0      (d0[DWIDTH*i +: DWIDTH]),
            .d1      (d1[DWIDTH*i +: DWIDTH]),
            .abs_sat (lane_abs[DWIDTH*i +: DWIDTH]),
            .pass    (lane_pass[i])
        );
    end

    // Stage 1 control: valid bit (dropped by clr) and the lane enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_lane_en <= '0;
        end else begin
            s1_valid <= dvalid & ~clr;
            if (dvalid) begin
                s1_lane_en <= lane_en;
            end
        end
    end

    // Disabled lanes always pass; a beat fails if any remaining lane fails.
    always_comb begin
        r_next    = lane_pass | ~s1_lane_en;
        beat_fail = s1_valid & ~(&r_next);
    end

    // Stage 2 results: pass flags, magnitudes, r_valid and the error pulse.
    // r and abs_sub hold their last compared values between beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r       <= '1;
            abs_sub <= '0;
            r_valid <= 1'b0;
            error   <= 1'b0;
        end else if (clr) begin
            r_valid <= 1'b0;
            error   <= 1'b0;
        end else begin
            r_valid <= s1_valid;
            error   <= beat_fail;
            if (s1_valid) begin
                r       <= r_next;
                abs_sub <= lane_abs;
            end
        end
    end

    // Stage 2 statistics: saturating beat/error counters and sticky flag,
    // updated in the same cycle the beat shows up on r_valid.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            beat_cnt   <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (s1_valid) begin
            beat_cnt <= CWIDTH'(sat_inc(CNT_MAXW'(beat_cnt), CNT_LIMIT));
            if (beat_fail) begin
                err_cnt    <= CWIDTH'(sat_inc(CNT_MAXW'(err_cnt), CNT_LIMIT));
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef STREAM_COMPARE_CAPTURE_EN
    logic [DWIDTH*N-1:0] s1_d0;
    logic [DWIDTH*N-1:0] s1_d1;

    // Stage 1 copy of the raw beat so the capture can record it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_d0 <= '0;
            s1_d1 <= '0;
        end else if (dvalid) begin
            s1_d0 <= d0;
            s1_d1 <= d1;
        end
    end

    // First-failure capture: latch once, hold until clr or reset. first_beat
    // is the pre-increment beat count, i.e. the 0-based index of the beat.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            first_valid <= 1'b0;
            first_beat  <= '0;
            first_mask  <= '0;
            first_d0    <= '0;
            first_d1    <= '0;
        end else if (beat_fail && !first_valid) begin
            first_valid <= 1'b1;
            first_beat  <= beat_cnt;
            first_mask  <= ~r_next;
            first_d0    <= s1_d0;
            first_d1    <= s1_d1;
        end
    end
`else
    // Capture not built: outputs held at their reset values.
    assign first_valid = 1'b0;
    assign first_beat  = '0;
    assign first_mask  = '0;
    assign first_d0    = '0;
    assign first_d1    = '0;
`endif

endmodule

// File: tb/tb_stream_compare.sv
// Bench for stream_compare. Four instances share one input stream:
//   dut0 exact/signed/32-bit counters, dut1 tolerance/signed/32,
//   dut2 exact/unsigned/4-bit counters, dut3 tolerance/unsigned/4.
// All use DWIDTH=16, N=4, ABDBIT=4.
module tb_stream_compare;

  localparam int W         = 164;  // {due[31:0], lane_en[3:0], d0[63:0], d1[63:0]}
  localparam int TOL_LIMIT = 16;   // 2**ABDBIT
`ifdef STREAM_COMPARE_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [63:0] d0;
  logic [63:0] d1;
  logic        dvalid;
  logic [3:0]  lane_en;

  logic [3:0]  o_r   [4];
  logic        o_rv  [4];
  logic [63:0] o_abs [4];
  logic        o_err [4];
  logic        o_stk [4];
  logic [31:0] o_bc  [4];
  logic [31:0] o_ec  [4];
  logic        o_fv  [4];
  logic [31:0] o_fb  [4];
  logic [3:0]  o_fm  [4];
  logic [63:0] o_fd0 [4];
  logic [63:0] o_fd1 [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int CW = (k < 2) ? 32 : 4;
    logic [CW-1:0] bc;
    logic [CW-1:0] ec;
    logic [CW-1:0] fb;
    stream_compare #(
      .DWIDTH (16),
      .N      (4),
      .MODE   (k % 2),
      .ABDBIT (4),
      .SIGNED ((k < 2) ? 1 : 0),
      .CWIDTH (CW)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .d0          (d0),
      .d1          (d1),
      .dvalid      (dvalid),
      .lane_en     (lane_en),
      .r           (o_r[k]),
      .r_valid     (o_rv[k]),
      .abs_sub     (o_abs[k]),
      .error       (o_err[k]),
      .err_sticky  (o_stk[k]),
      .beat_cnt    (bc),
      .err_cnt     (ec),
      .first_valid (o_fv[k]),
      .first_beat  (fb),
      .first_mask  (o_fm[k]),
      .first_d0    (o_fd0[k]),
      .first_d1    (o_fd1[k])
    );
    assign o_bc[k] = 32'(bc);
    assign o_ec[k] = 32'(ec);
    assign o_fb[k] = 32'(fb);
  end

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc    = 0;
  bit mon_en = 1'b0;
  int n_pass  = 0;
  int n_total = 0;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_beat [4];
  logic [31:0]  m_err  [4];
  logic         m_stk  [4];
  logic         m_fv   [4];
  logic [31:0]  m_fb   [4];
  logic [3:0]   m_fm   [4];
  logic [63:0]  m_fd0  [4];
  logic [63:0]  m_fd1  [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic string nm(input int k, input string s);
    return $sformatf("dut%0d %s", k, s);
  endfunction

  function automatic logic [31:0] cmax(input int k);
    return (k < 2) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  // Reference: per lane, exact integer difference of the operands read as
  // signed or unsigned numbers; magnitude clipped to 16 bits for abs_sub.
  function automatic void eval(input logic [63:0] a, input logic [63:0] b, input logic [3:0] en,
                               input int k, output logic [3:0] rr, output logic [63:0] ab);
    bit sgn;
    bit tol;
    sgn = (k < 2);
    tol = (k % 2 == 1);
    rr = '0;
    ab = '0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      int va;
      int vb;
      int diff;
      int mag;
      x = a[16*i +: 16];
      y = b[16*i +: 16];
      va = sgn ? int'($signed(x)) : int'(x);
      vb = sgn ? int'($signed(y)) : int'(y);
      diff = va - vb;
      mag = (diff < 0) ? -diff : diff;
      ab[16*i +: 16] = 16'((mag > 65535) ? 65535 : mag);
      rr[i] = !en[i] || (tol ? (mag < TOL_LIMIT) : (x == y));
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      m_beat[k] = '0;
      m_err[k]  = '0;
      m_stk[k]  = 1'b0;
      m_fv[k]   = 1'b0;
      m_fb[k]   = '0;
      m_fm[k]   = '0;
      m_fd0[k]  = '0;
      m_fd1[k]  = '0;
    end
  endfunction

  task automatic check_cycle();
    logic         hv;
    logic [W-1:0] e;
    logic [3:0]   rr;
    logic [63:0]  ab;
    hv = (exp_q.size() > 0) && (exp_q[0][163:132] == 32'(cyc));
    e = hv ? exp_q[0] : '0;
    for (int k = 0; k < 4; k++) begin
      check(nm(k, "r_valid"), 64'(o_rv[k]), 64'(hv));
      if (hv) begin
        eval(e[127:64], e[63:0], e[131:128], k, rr, ab);
        check(nm(k, "r"), 64'(o_r[k]), 64'(rr));
        check(nm(k, "abs_sub"), o_abs[k], ab);
        check(nm(k, "error"), 64'(o_err[k]), 64'(~&rr));
        if (!(&rr)) begin
          if (CAP && !m_fv[k]) begin
            m_fv[k]  = 1'b1;
            m_fb[k]  = m_beat[k];
            m_fm[k]  = ~rr;
            m_fd0[k] = e[127:64];
            m_fd1[k] = e[63:0];
          end
          if (m_err[k] != cmax(k)) m_err[k] = m_err[k] + 1;
          m_stk[k] = 1'b1;
        end
        if (m_beat[k] != cmax(k)) m_beat[k] = m_beat[k] + 1;
      end else begin
        check(nm(k, "error idle"), 64'(o_err[k]), 64'd0);
      end
      check(nm(k, "err_sticky"), 64'(o_stk[k]), 64'(m_stk[k]));
      check(nm(k, "beat_cnt"), 64'(o_bc[k]), 64'(m_beat[k]));
      check(nm(k, "err_cnt"), 64'(o_ec[k]), 64'(m_err[k]));
      check(nm(k, "first_valid"), 64'(o_fv[k]), 64'(m_fv[k]));
      check(nm(k, "first_beat"), 64'(o_fb[k]), 64'(m_fb[k]));
      check(nm(k, "first_mask"), 64'(o_fm[k]), 64'(m_fm[k]));
      check(nm(k, "first_d0"), o_fd0[k], m_fd0[k]);
      check(nm(k, "first_d1"), o_fd1[k], m_fd1[k]);
    end
    if (hv) void'(exp_q.pop_front());
  endtask

  // Monitor: samples 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) check_cycle();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] en, input logic c, input logic rs);
    @(negedge clk);
    dvalid  = v;
    d0      = a;
    d1      = b;
    lane_en = en;
    clr     = c;
    rst_n   = rs;
    if (!rs || c) model_clear();
    else if (v) exp_q.push_back({32'(cyc + 2), en, a, b});
  endtask

  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] en);
    drive(1'b1, a, b, en, 1'b0, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b1);
  endtask

  task automatic clear();
    drive(1'b0, 64'd0, 64'd0, 4'hF, 1'b1, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 4; k++) begin
      check(nm(k, {tag, " r_valid"}), 64'(o_rv[k]), 64'd0);
      check(nm(k, {tag, " r"}), 64'(o_r[k]), 64'hF);
      check(nm(k, {tag, " abs_sub"}), o_abs[k], 64'd0);
      check(nm(k, {tag, " error"}), 64'(o_err[k]), 64'd0);
      check(nm(k, {tag, " err_sticky"}), 64'(o_stk[k]), 64'd0);
      check(nm(k, {tag, " beat_cnt"}), 64'(o_bc[k]), 64'd0);
      check(nm(k, {tag, " err_cnt"}), 64'(o_ec[k]), 64'd0);
      check(nm(k, {tag, " first_valid"}), 64'(o_fv[k]), 64'd0);
      check(nm(k, {tag, " first_beat"}), 64'(o_fb[k]), 64'd0);
      check(nm(k, {tag, " first_mask"}), 64'(o_fm[k]), 64'd0);
      check(nm(k, {tag, " first_d0"}), o_fd0[k], 64'd0);
      check(nm(k, {tag, " first_d1"}), o_fd1[k], 64'd0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [3:0]  en;
    logic [3:0]  r_exp [4];
    logic [15:0] abs_s;  // lane 0 magnitude, signed instances
    logic [15:0] abs_u;  // lane 0 magnitude, unsigned instances
  } vec_t;

  vec_t vecs[10];

  task automatic set_vec(input int i, input logic [63:0] a, input logic [63:0] b, input logic [3:0] en,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                         input logic [3:0] rd, input logic [15:0] abs_s, input logic [15:0] abs_u);
    vecs[i].d0 = a;
    vecs[i].d1 = b;
    vecs[i].en = en;
    vecs[i].r_exp[0] = ra;
    vecs[i].r_exp[1] = rb;
    vecs[i].r_exp[2] = rc;
    vecs[i].r_exp[3] = rd;
    vecs[i].abs_s = abs_s;
    vecs[i].abs_u = abs_u;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  en;
    rst_n = 1'b0; clr = 1'b0; dvalid = 1'b0; d0 = '0; d1 = '0; lane_en = 4'hF;
    model_clear();

    // lane 0 carries the interesting case; other lanes equal unless noted
    set_vec(0, 64'h0000_0000_0000_FFF8, 64'h0000_0000_0000_0007, 4'hF, 4'b1110, 4'b1111, 4'b1110, 4'b1110, 16'h000F, 16'hFFF1);
    set_vec(1, 64'h0000_0000_0000_FFF8, 64'h0000_0000_0000_0008, 4'hF, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 16'h0010, 16'hFFF0);
    set_vec(2, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_8000, 4'hF, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 16'hFFFF, 16'h0001);
    set_vec(3, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_FFFF, 4'hF, 4'b1110, 4'b1111, 4'b1110, 4'b1110, 16'h0001, 16'hFFFF);
    set_vec(4, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1235, 4'hE, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 16'h0001, 16'h0001);
    set_vec(5, 64'hABCD_0123_8000_7FFF, 64'hABCD_0123_8000_7FFF, 4'hF, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 16'h0000, 16'h0000);
    set_vec(6, 64'h0000_0100_0000_0000, 64'h0000_0101_0000_0000, 4'hF, 4'b1011, 4'b1111, 4'b1011, 4'b1111, 16'h0000, 16'h0000);
    set_vec(7, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_7FFF, 4'hF, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 16'hFFFF, 16'h0001);
    set_vec(8, 64'h0010_0000_0000_0000, 64'h0000_0000_0000_0000, 4'hF, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 16'h0000, 16'h0000);
    set_vec(9, 64'h0000_0000_0000_0000, 64'h0000_0000_000F_0000, 4'hF, 4'b1101, 4'b1111, 4'b1101, 4'b1111, 16'h0000, 16'h0000);

    // power-on reset
    drive(1'b0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0);
    mon_en = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0);
    chk_reset("reset");
    idle();

    // table: one beat each, inspected two cycles after it was presented
    for (int i = 0; i < 10; i++) begin
      beat(vecs[i].d0, vecs[i].d1, vecs[i].en);
      idle();
      idle();
      for (int k = 0; k < 4; k++) begin
        check(nm(k, $sformatf("vec%0d r_valid", i)), 64'(o_rv[k]), 64'd1);
        check(nm(k, $sformatf("vec%0d r", i)), 64'(o_r[k]), 64'(vecs[i].r_exp[k]));
        check(nm(k, $sformatf("vec%0d error", i)), 64'(o_err[k]), 64'(~&vecs[i].r_exp[k]));
        check(nm(k, $sformatf("vec%0d abs lane0", i)), 64'(o_abs[k][15:0]),
              64'((k < 2) ? vecs[i].abs_s : vecs[i].abs_u));
      end
    end

    // exact pass stream with one lane-2 fault on beat 5
    clear();
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      b = a;
      if (i == 5) b[47:32] = a[47:32] + 16'd1;
      beat(a, b, 4'hF);
    end
    idle();
    idle();
    check("seq exact beat_cnt", 64'(o_bc[0]), 64'd10);
    check("seq exact err_cnt", 64'(o_ec[0]), 64'd1);
    check("seq exact err_sticky", 64'(o_stk[0]), 64'd1);
    check("seq exact first_beat", 64'(o_fb[0]), CAP ? 64'd5 : 64'd0);
    check("seq exact first_mask", 64'(o_fm[0]), CAP ? 64'h4 : 64'h0);
    check("seq tol err_cnt", 64'(o_ec[1]), 64'd0);

    // clr with two beats in flight: neither may come out
    clear();
    beat(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 4'hF);
    drive(1'b1, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 4'hF, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) begin
      idle();
      for (int k = 0; k < 4; k++) begin
        check(nm(k, "clr flush r_valid"), 64'(o_rv[k]), 64'd0);
        check(nm(k, "clr flush beat_cnt"), 64'(o_bc[k]), 64'd0);
        check(nm(k, "clr flush err_sticky"), 64'(o_stk[k]), 64'd0);
      end
    end

    // counter saturation on the 4-bit instances
    clear();
    for (int i = 0; i < 20; i++) beat(64'h0000_0000_0000_0000, 64'h0000_0000_0000_FFFF, 4'hF);
    idle();
    idle();
    check("sat dut2 beat_cnt", 64'(o_bc[2]), 64'hF);
    check("sat dut2 err_cnt", 64'(o_ec[2]), 64'hF);
    check("sat dut3 beat_cnt", 64'(o_bc[3]), 64'hF);
    check("sat dut3 err_cnt", 64'(o_ec[3]), 64'hF);
    check("sat dut0 beat_cnt", 64'(o_bc[0]), 64'd20);
    check("sat dut1 err_cnt", 64'(o_ec[1]), 64'd0);

    // reset in the middle of a failing stream
    for (int i = 0; i < 3; i++) beat(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0000, 4'hF);
    drive(1'b1, 64'h1, 64'h2, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 64'h1, 64'h2, 4'hF, 1'b0, 1'b0);
    chk_reset("mid reset");
    idle();
    idle();

    // randomized stream against the reference model
    for (int n = 0; n < 600; n++) begin
      logic v;
      logic c;
      logic rs;
      a = {$urandom, $urandom};
      b = a;
      for (int i = 0; i < 4; i++) begin
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 1) b[16*i +: 16] = a[16*i +: 16] + 16'($urandom_range(0, 40)) - 16'd20;
        else if (sel == 2) b[16*i +: 16] = 16'($urandom);
      end
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      v  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 199) != 0);
      drive(v, a, b, en, c, rs);
    end
    idle();
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
